// File: rtl/trap_ctrl_pkg.sv
// rtl/trap_ctrl_pkg.sv - shared encodings for the trap/interrupt sequencer
package trap_ctrl_pkg;

  // NPC op codes seen by the next-PC unit
  localparam logic [2:0] NPC_PLUS4   = 3'b000;
  localparam logic [2:0] NPC_INT     = 3'b101;
  localparam logic [2:0] NPC_INT_RET = 3'b110;

  // Cause codes reported on int_pend
  localparam logic [2:0] INT_NONE          = 3'd0;
  localparam logic [2:0] INT_TIMER         = 3'd1;
  localparam logic [2:0] INT_ILLEGAL_INSTR = 3'd2;
  localparam logic [2:0] INT_ECALL         = 3'd3;

  // Bit positions inside the raw cause vector fed to the priority encoder
  localparam int CV_TIMER   = 0;
  localparam int CV_ECALL   = 1;
  localparam int CV_ILLEGAL = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTER   = 2'd1,
    ST_HANDLER = 2'd2,
    ST_RETURN  = 2'd3
  } state_e;

endpackage

// File: rtl/trap_ctrl_if.sv
// rtl/trap_ctrl_if.sv - EX-stage / next-PC bundle between pipeline and trap sequencer
interface trap_ctrl_if #(
  parameter int XLEN = 32
) ();

  logic            pc_write;
  logic            ex_valid;
  logic [XLEN-1:0] pc_ex;
  logic            illegal_ex;
  logic            ecall_ex;
  logic            sret_ex;

  logic            npc_ovr;
  logic [2:0]      npc_op;
  logic            int_signal;
  logic [2:0]      int_pend;
  logic            exl;
  logic [XLEN-1:0] sepc;
  logic            flush;

  // Pipeline side
  modport master (
    output pc_write, ex_valid, pc_ex, illegal_ex, ecall_ex, sret_ex,
    input  npc_ovr, npc_op, int_signal, int_pend, exl, sepc, flush
  );

  // Trap sequencer side
  modport slave (
    input  pc_write, ex_valid, pc_ex, illegal_ex, ecall_ex, sret_ex,
    output npc_ovr, npc_op, int_signal, int_pend, exl, sepc, flush
  );

endinterface

// File: rtl/trap_prio_enc.sv
// rtl/trap_prio_enc.sv - fixed-priority encoder from raw cause vector to cause code
module trap_prio_enc
  import trap_ctrl_pkg::*;
(
  input  logic [2:0] cause_vec,
  output logic [2:0] cause,
  output logic       valid
);

  // Illegal beats ecall beats timer; lower causes are simply dropped
  always_comb begin
    cause = INT_NONE;
    valid = 1'b0;
    if (cause_vec[CV_ILLEGAL]) begin
      cause = INT_ILLEGAL_INSTR;
      valid = 1'b1;
    end else if (cause_vec[CV_ECALL]) begin
      cause = INT_ECALL;
      valid = 1'b1;
    end else if (cause_vec[CV_TIMER]) begin
      cause = INT_TIMER;
      valid = 1'b1;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - trap entry/return sequencer driving the NPC override
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit TIMER_EN_RST = 1'b1
) (
  input  logic       clk,
  input  logic       rstn,
  trap_ctrl_if.slave bus,
  input  logic       timer_irq,
  input  logic       timer_en_wr,
  input  logic       timer_en_din,
  output logic       dbl_fault
);

  state_e          state_q, state_d;
  logic            exl_q, exl_d;
  logic [XLEN-1:0] sepc_q, sepc_d;
  logic [2:0]      int_pend_q, int_pend_d;
  logic            timer_en_q, timer_en_d;
  logic            timer_pend_q, timer_pend_d;
  logic            dbl_fault_q, dbl_fault_d;

  logic [2:0]      cause_vec;
  logic [2:0]      cause;
  logic            cause_valid;
  logic            take_timer;
  logic            npc_ovr;
  logic [2:0]      npc_op;
  logic            int_signal;
  logic            flush;

  // Trap-return outside a handler is treated as illegal; an enable write blocks timer acceptance
  assign cause_vec[CV_ILLEGAL] = bus.illegal_ex | bus.sret_ex;
  assign cause_vec[CV_ECALL]   = bus.ecall_ex;
  assign cause_vec[CV_TIMER]   = timer_pend_q & ~timer_en_wr;

  trap_prio_enc u_prio (
    .cause_vec (cause_vec),
    .cause     (cause),
    .valid     (cause_valid)
  );

  // Timer enable register and level-to-pending latch
  always_comb begin
    timer_en_d   = timer_en_wr ? timer_en_din : timer_en_q;
    timer_pend_d = timer_pend_q | (timer_irq & timer_en_q);
    if (take_timer || (timer_en_wr && !timer_en_din)) begin
      timer_pend_d = 1'b0;
    end
  end

  // Sequencer next state and redirect outputs
  always_comb begin
    state_d     = state_q;
    exl_d       = exl_q;
    sepc_d      = sepc_q;
    int_pend_d  = int_pend_q;
    dbl_fault_d = dbl_fault_q;
    take_timer  = 1'b0;
    npc_ovr     = 1'b0;
    npc_op      = NPC_PLUS4;
    int_signal  = 1'b0;
    flush       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.ex_valid && !exl_q && cause_valid) begin
          sepc_d     = bus.pc_ex;
          int_pend_d = cause;
          take_timer = (cause == INT_TIMER);
          state_d    = ST_ENTER;
        end
      end
      ST_ENTER: begin
        npc_ovr = 1'b1;
        npc_op  = NPC_INT;
        flush   = 1'b1;
        if (bus.pc_write) begin
          int_signal = 1'b1;
          exl_d      = 1'b1;
          state_d    = ST_HANDLER;
        end
      end
      ST_HANDLER: begin
        if (bus.ex_valid && bus.sret_ex) begin
          state_d = ST_RETURN;
        end else if (bus.ex_valid && (bus.illegal_ex || bus.ecall_ex)) begin
          dbl_fault_d = 1'b1;
        end
      end
      ST_RETURN: begin
        npc_ovr = 1'b1;
        npc_op  = NPC_INT_RET;
        flush   = 1'b1;
        if (bus.pc_write) begin
          exl_d      = 1'b0;
          int_pend_d = INT_NONE;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      exl_q        <= 1'b0;
      sepc_q       <= '0;
      int_pend_q   <= INT_NONE;
      timer_en_q   <= TIMER_EN_RST;
      timer_pend_q <= 1'b0;
      dbl_fault_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      exl_q        <= exl_d;
      sepc_q       <= sepc_d;
      int_pend_q   <= int_pend_d;
      timer_en_q   <= timer_en_d;
      timer_pend_q <= timer_pend_d;
      dbl_fault_q  <= dbl_fault_d;
    end
  end

  assign bus.npc_ovr    = npc_ovr;
  assign bus.npc_op     = npc_op;
  assign bus.int_signal = int_signal;
  assign bus.int_pend   = int_pend_q;
  assign bus.exl        = exl_q;
  assign bus.sepc       = sepc_q;
  assign bus.flush      = flush;
  assign dbl_fault      = dbl_fault_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - self-checking bench for trap_ctrl
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  logic timer_irq, timer_en_wr, timer_en_din;
  logic dbl_fault;

  trap_ctrl_if #(.XLEN(32)) bus ();

  trap_ctrl #(.XLEN(32), .TIMER_EN_RST(1'b1)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .bus          (bus),
    .timer_irq    (timer_irq),
    .timer_en_wr  (timer_en_wr),
    .timer_en_din (timer_en_din),
    .dbl_fault    (dbl_fault)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a redirect is either pending (with its op) or not; the
  // handler flag, saved PC, cause, timer enable/pending and sticky fault are plain variables.
  bit          m_init = 1'b0;
  bit          m_exl, m_en, m_pend, m_dbl;
  logic [31:0] m_sepc;
  logic [2:0]  m_cause;
  logic [2:0]  m_redir;

  always @(posedge clk) begin
    bit took_timer;
    bit next_pend;
    bit taken;
    if (!rstn) begin
      m_init = 1'b1; m_exl = 1'b0; m_en = 1'b1; m_pend = 1'b0; m_dbl = 1'b0;
      m_sepc = 32'h0; m_cause = 3'd0; m_redir = 3'd0;
    end else if (m_init) begin
      took_timer = 1'b0;
      taken      = 1'b0;
      next_pend  = m_pend | (timer_irq & m_en);
      if (m_redir == NPC_INT) begin
        if (bus.pc_write) begin m_exl = 1'b1; m_redir = 3'd0; end
      end else if (m_redir == NPC_INT_RET) begin
        if (bus.pc_write) begin m_exl = 1'b0; m_cause = 3'd0; m_redir = 3'd0; end
      end else if (!m_exl) begin
        if (bus.ex_valid) begin
          if (bus.illegal_ex || bus.sret_ex) begin m_cause = 3'd2; taken = 1'b1; end
          else if (bus.ecall_ex) begin m_cause = 3'd3; taken = 1'b1; end
          else if (m_pend && !timer_en_wr) begin m_cause = 3'd1; taken = 1'b1; took_timer = 1'b1; end
          if (taken) begin m_sepc = bus.pc_ex; m_redir = NPC_INT; end
        end
      end else if (bus.ex_valid) begin
        if (bus.sret_ex) m_redir = NPC_INT_RET;
        else if (bus.illegal_ex || bus.ecall_ex) m_dbl = 1'b1;
      end
      if (timer_en_wr) m_en = timer_en_din;
      if (took_timer || (timer_en_wr && !timer_en_din)) next_pend = 1'b0;
      m_pend = next_pend;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (m_init) begin
      chk("npc_ovr",    bus.npc_ovr,    32'(m_redir != 3'd0));
      chk("npc_op",     bus.npc_op,     32'((m_redir != 3'd0) ? m_redir : NPC_PLUS4));
      chk("flush",      bus.flush,      32'(m_redir != 3'd0));
      chk("int_signal", bus.int_signal, 32'((m_redir == NPC_INT) && bus.pc_write));
      chk("int_pend",   bus.int_pend,   32'(m_cause));
      chk("exl",        bus.exl,        32'(m_exl));
      chk("sepc",       bus.sepc,       m_sepc);
      chk("dbl_fault",  dbl_fault,      32'(m_dbl));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.ex_valid = 1'b0; bus.illegal_ex = 1'b0; bus.ecall_ex = 1'b0; bus.sret_ex = 1'b0;
    timer_irq = 1'b0; timer_en_wr = 1'b0; timer_en_din = 1'b0;
  endtask

  task automatic ex(input logic [31:0] pc, input bit ill, input bit ec, input bit sr);
    bus.ex_valid = 1'b1; bus.pc_ex = pc;
    bus.illegal_ex = ill; bus.ecall_ex = ec; bus.sret_ex = sr;
    tick();
    clr();
  endtask

  task automatic do_return();
    ex(32'h0000_0ff0, 1'b0, 1'b0, 1'b1);
    chk("ret_ovr", bus.npc_ovr, 32'd1);
    chk("ret_op",  bus.npc_op,  32'h6);
    tick();
    chk("ret_exl",  bus.exl,      32'd0);
    chk("ret_pend", bus.int_pend, 32'd0);
  endtask

  initial begin
    // Reset with every request active
    rstn = 1'b0; bus.pc_write = 1'b1; bus.pc_ex = 32'hdead_beef;
    bus.ex_valid = 1'b1; bus.illegal_ex = 1'b1; bus.ecall_ex = 1'b1; bus.sret_ex = 1'b1;
    timer_irq = 1'b1; timer_en_wr = 1'b1; timer_en_din = 1'b1;
    tick(); tick();
    chk("rst_exl", bus.exl, 32'd0);
    chk("rst_sepc", bus.sepc, 32'd0);
    chk("rst_pend", bus.int_pend, 32'd0);
    chk("rst_ovr", bus.npc_ovr, 32'd0);
    chk("rst_dbl", dbl_fault, 32'd0);
    clr(); rstn = 1'b1;
    tick();

    // ecall entry then return
    ex(32'h100, 1'b0, 1'b1, 1'b0);
    chk("ec_ovr", bus.npc_ovr, 32'd1);
    chk("ec_op", bus.npc_op, 32'h5);
    chk("ec_sig", bus.int_signal, 32'd1);
    chk("ec_pend", bus.int_pend, 32'd3);
    chk("ec_sepc", bus.sepc, 32'h100);
    chk("ec_flush", bus.flush, 32'd1);
    tick();
    chk("ec_exl", bus.exl, 32'd1);
    chk("ec_sig_once", bus.int_signal, 32'd0);
    chk("ec_op_plus4", bus.npc_op, 32'h0);
    do_return();

    // All causes at once; timer remains pending and is taken after return
    timer_irq = 1'b1;
    ex(32'h200, 1'b1, 1'b1, 1'b0);
    chk("multi_pend", bus.int_pend, 32'd2);
    chk("multi_sepc", bus.sepc, 32'h200);
    tick();
    do_return();
    ex(32'h300, 1'b0, 1'b0, 1'b0);
    chk("tmr_pend", bus.int_pend, 32'd1);
    chk("tmr_sepc", bus.sepc, 32'h300);
    chk("tmr_op", bus.npc_op, 32'h5);
    tick();
    do_return();

    // Stalled entry, then double fault inside the handler
    ex(32'h400, 1'b0, 1'b1, 1'b0);
    bus.pc_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ovr", bus.npc_ovr, 32'd1);
      chk("stall_flush", bus.flush, 32'd1);
      chk("stall_sig", bus.int_signal, 32'd0);
      tick();
    end
    bus.pc_write = 1'b1;
    #1;
    chk("stall_sig_rel", bus.int_signal, 32'd1);
    tick();
    chk("stall_exl", bus.exl, 32'd1);
    ex(32'h404, 1'b0, 1'b1, 1'b0);
    chk("dbl_set", dbl_fault, 32'd1);
    chk("dbl_noredir", bus.npc_ovr, 32'd0);
    chk("dbl_sepc", bus.sepc, 32'h400);
    do_return();
    chk("dbl_sticky", dbl_fault, 32'd1);

    // Timer masked inside handler, taken after return
    ex(32'h500, 1'b0, 1'b1, 1'b0);
    tick();
    timer_irq = 1'b1;
    tick();
    clr();
    ex(32'h504, 1'b0, 1'b0, 1'b0);
    chk("mask_ovr", bus.npc_ovr, 32'd0);
    do_return();
    ex(32'h600, 1'b0, 1'b0, 1'b0);
    chk("late_pend", bus.int_pend, 32'd1);
    chk("late_sepc", bus.sepc, 32'h600);
    tick();
    do_return();

    // Timer disabled: never taken
    timer_en_wr = 1'b1; timer_en_din = 1'b0;
    tick(); clr();
    timer_irq = 1'b1;
    tick(); clr();
    for (int i = 0; i < 3; i++) begin
      ex(32'h700 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
      chk("dis_ovr", bus.npc_ovr, 32'd0);
    end

    // Enable write in the acceptance cycle wins; timer taken one instruction later
    timer_en_wr = 1'b1; timer_en_din = 1'b1;
    tick(); clr();
    timer_irq = 1'b1;
    tick(); clr();
    timer_en_wr = 1'b1; timer_en_din = 1'b1;
    ex(32'h800, 1'b0, 1'b0, 1'b0);
    chk("wr_wins_ovr", bus.npc_ovr, 32'd0);
    ex(32'h804, 1'b0, 1'b0, 1'b0);
    chk("wr_after_ovr", bus.npc_ovr, 32'd1);
    chk("wr_after_pend", bus.int_pend, 32'd1);
    chk("wr_after_sepc", bus.sepc, 32'h804);
    tick();
    do_return();

    // Reset in the middle of a stalled entry
    ex(32'h900, 1'b0, 1'b1, 1'b0);
    bus.pc_write = 1'b0;
    #1;
    chk("mid_ovr", bus.npc_ovr, 32'd1);
    rstn = 1'b0;
    tick();
    chk("mid_rst_ovr", bus.npc_ovr, 32'd0);
    chk("mid_rst_exl", bus.exl, 32'd0);
    chk("mid_rst_dbl", dbl_fault, 32'd0);
    chk("mid_rst_sepc", bus.sepc, 32'd0);
    rstn = 1'b1; bus.pc_write = 1'b1;
    tick();
    chk("post_rst_ovr", bus.npc_ovr, 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap/interrupt sequencer for the `NPC` next-PC unit.
- Collects the timer interrupt plus the synchronous EX-stage exceptions (illegal instruction, ecall) and the trap-return instruction.
- Arbitrates among them by fixed priority and owns the exception-level (EXL) state and the saved EPC.
- Drives the NPC op override (`NPC_INT` / `NPC_INT_RET`), `INT_Signal`, `EXL_Set`, `INT_PEND` and the pipeline flush.

Parameters:
- XLEN, 32, PC/data width.
- TIMER_EN_RST, 1, reset value of the timer-interrupt enable bit.

Ports:
- clk  in  1  core clock
- rstn  in  1  synchronous active-low reset
- pc_write  in  1  PC update permitted this cycle (0 = pipeline stalled)
- ex_valid  in  1  EX stage holds a valid, non-flushed instruction
- pc_ex  in  XLEN  PC of the EX-stage instruction
- illegal_ex  in  1  EX instruction is illegal
- ecall_ex  in  1  EX instruction is ecall
- sret_ex  in  1  EX instruction is trap-return
- timer_irq  in  1  level timer interrupt request
- timer_en_wr  in  1  write strobe for the timer enable bit
- timer_en_din  in  1  timer enable write data
- npc_ovr  out  1  override NPCOp with npc_op this cycle
- npc_op  out  3  `NPC_INT` or `NPC_INT_RET` when npc_ovr=1, else `NPC_PLUS4`
- int_signal  out  1  one-cycle trap-entry pulse (to NPC `INT_Signal`)
- int_pend  out  3  cause code (to NPC `INT_PEND`)
- exl  out  1  in-handler flag (to NPC `EXL_Set`)
- sepc  out  XLEN  saved exception PC
- flush  out  1  flush IF/ID/EX on redirect
- dbl_fault  out  1  sticky: synchronous exception occurred while exl=1

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE, exl=0, sepc=0, int_pend=`int_none`, timer_en=TIMER_EN_RST, timer pending latch cleared, dbl_fault=0; npc_ovr/int_signal/flush=0. Reset mid-sequence aborts it with no redirect.
- timer_pend latch:
  - set when timer_irq=1 && timer_en=1;
  - cleared when the timer trap is accepted or timer_en is written 0.
- Cause priority, evaluated in IDLE with ex_valid=1 and exl=0, highest first:
  - illegal_ex (also sret_ex while exl=0);
  - ecall_ex;
  - timer_pend.
- IDLE, cause accepted at posedge t:
  - sepc<=pc_ex, int_pend<=cause, go to ENTER.
  - Timer is masked while exl=1.
- ENTER:
  - npc_ovr=1, npc_op=`NPC_INT`, flush=1, held until pc_write=1.
  - In the cycle pc_write=1: int_signal=1 (exactly one cycle), exl<=1, go to HANDLER.
  - Minimum trap latency is cause at edge t → redirect visible in cycle t+1.
- HANDLER:
  - sret_ex && ex_valid → go to RETURN.
  - illegal_ex/ecall_ex && ex_valid → dbl_fault<=1, ignored, no redirect.
  - timer_pend stays latched.
- RETURN:
  - npc_ovr=1, npc_op=`NPC_INT_RET`, flush=1, held until pc_write=1.
  - In that cycle: exl<=0, int_pend<=`int_none`, go to IDLE.
  - A pending timer can be accepted from the next valid EX instruction.
- Simultaneous events:
  - Several causes in one cycle → highest priority taken, lower synchronous causes dropped (the instruction is flushed), timer stays pending.
  - timer_en_wr in the same cycle as timer acceptance → the write wins, timer not taken.
- sepc is stable from ENTER until the next accepted trap. It is not modified on return; the NPC adds +4.
- npc_op=`NPC_PLUS4` whenever npc_ovr=0. The downstream mux selects the decoder's NPCOp in that case.

Decomposition:
- Shared in `ctrl_encode_def.v`:
  - `NPC_INT`=3'b101, `NPC_INT_RET`=3'b110;
  - `int_none`=3'd0, `int_timer`=3'd1, `int_illegal_instr`=3'd2, `int_ecall`=3'd3;
  - state encodings IDLE/ENTER/HANDLER/RETURN.
- One natural sub-module: `trap_prio_enc`, a combinational priority encoder from the cause vector to cause code plus valid.

Test Plan:
- Reset: hold rstn=0 for 2 cycles with all requests active → exl=0, sepc=0, int_pend=0, npc_ovr=0, dbl_fault=0.
- ecall at pc_ex=0x100, pc_write=1 → next cycle npc_ovr=1, npc_op=3'b101, int_signal=1 for 1 cycle, int_pend=3, sepc=0x100, exl=1. Then sret_ex → npc_op=3'b110 for one pc_write cycle, exl=0.
- illegal_ex + ecall_ex + timer_irq together at pc_ex=0x200 → int_pend=2, sepc=0x200. After sret, the timer is taken at the next valid instruction (pc_ex=0x300) → int_pend=1, sepc=0x300.
- Stall: ecall accepted, then pc_write=0 for 3 cycles → npc_ovr/flush held 3 cycles, int_signal=0. On pc_write=1 → int_signal pulses once, exl=1.
- timer_irq asserted while exl=1 → no redirect. After return → taken. Repeat with timer_en written 0 first → never taken.
- ecall during HANDLER → dbl_fault=1 (sticky), no redirect. Assert rstn=0 mid-ENTER → state IDLE, npc_ovr=0 the next cycle.
